dist_sort_result_checker: RTL and testbench

//  Hardware-side consumer of the dist_sort output stream. Holds a golden table of expected
//  (addr_1st, addr_2nd) pairs, captures every out_valid beat from dist_sort, compares it
//  in order against the table and accumulates pass/error counts. Sits directly on the

---
 rtl/dist_sort_result_checker_if.sv | 19 +
 rtl/dist_sort_result_checker.sv | 190 +++++++++++++++++++
 tb/tb_dist_sort_result_checker.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_sort_result_checker_if.sv
//------------------------------------------------------------------------------
// Module  : dist_sort_result_checker_if
// Brief   : dist_sort result stream (valid + nearest/second-nearest address).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dist_sort_result_checker_if #(
  parameter int ADDR_W = 3
);
  logic              out_valid;
  logic [ADDR_W-1:0] addr_1st;
  logic [ADDR_W-1:0] addr_2nd;

  modport master (output out_valid, output addr_1st, output addr_2nd);
  modport slave  (input  out_valid, input  addr_1st, input  addr_2nd);
endinterface

`default_nettype wire

// File: rtl/dist_sort_result_checker.sv
//------------------------------------------------------------------------------
// Module  : dist_sort_result_checker
// Brief   : Compares the dist_sort result stream in order against a golden table
//           and counts pass/error beats. FIRST_ERR_CAPTURE_EN adds first-mismatch capture.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dist_sort_result_checker #(
  parameter  int DEPTH  = 1000,
  parameter  int ADDR_W = 3,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        gold_we,
  input  logic [IDX_W-1:0]            gold_waddr,
  input  logic [ADDR_W-1:0]           gold_wdata_1st,
  input  logic [ADDR_W-1:0]           gold_wdata_2nd,
  input  logic                        start,
  dist_sort_result_checker_if.slave   res,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W:0]              pass_cnt,
  output logic [IDX_W:0]              err_cnt,
  output logic                        overflow
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic                        first_err_vld,
  output logic [IDX_W-1:0]            first_err_idx,
  output logic [2*ADDR_W-1:0]         first_err_got,
  output logic [2*ADDR_W-1:0]         first_err_exp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] c_one   = (IDX_W+1)'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W:0]        r_k;
  logic                  r_cap_vld;
  logic [ADDR_W-1:0]     r_cap_1st;
  logic [ADDR_W-1:0]     r_cap_2nd;
  logic [IDX_W-1:0]      r_cap_idx;
  logic [IDX_W:0]        r_pass_cnt;
  logic [IDX_W:0]        r_err_cnt;
  logic                  r_overflow;
  logic [2*ADDR_W-1:0]   r_gold [DEPTH];

  logic                  w_start_run;
  logic                  w_capture;
  logic                  w_ovf_set;
  logic                  w_gold_wr;
  logic                  w_waddr_ok;
  logic [2*ADDR_W-1:0]   w_gold_rd;
  logic [2*ADDR_W-1:0]   w_cap_pair;
  logic                  w_match;

  assign w_waddr_ok = ({1'b0, gold_waddr} < c_depth);
  assign w_gold_rd  = r_gold[r_cap_idx];
  assign w_cap_pair = {r_cap_1st, r_cap_2nd};
  assign w_match    = (w_cap_pair == w_gold_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A beat arriving on the start cycle becomes index 0 of the new run.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_capture   = 1'b0;
    w_ovf_set   = 1'b0;
    w_gold_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gold_wr = gold_we && w_waddr_ok;
        if (start) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
          w_capture   = res.out_valid;
        end
      end
      S_RUN: begin
        if (res.out_valid) begin
          if (r_k < c_depth) w_capture = 1'b1;
          else               w_ovf_set = 1'b1;
        end
        if ((r_k == c_depth) && !r_cap_vld) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_gold_wr = gold_we && w_waddr_ok;
        if (start) begin
          w_state_nxt = S_RUN;
          w_start_run = 1'b1;
          w_capture   = res.out_valid;
        end else begin
          w_ovf_set   = res.out_valid;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Golden table deliberately has no reset so it survives a run abort.
  always_ff @(posedge clk) begin
    if (w_gold_wr) r_gold[gold_waddr] <= {gold_wdata_1st, gold_wdata_2nd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_1st  <= '0;
      r_cap_2nd  <= '0;
      r_cap_idx  <= '0;
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cap_vld <= w_capture;
      if (w_capture) begin
        r_cap_1st <= res.addr_1st;
        r_cap_2nd <= res.addr_2nd;
        r_cap_idx <= w_start_run ? '0 : r_k[IDX_W-1:0];
      end
      if (w_start_run) begin
        r_k        <= w_capture ? c_one : '0;
        r_pass_cnt <= '0;
        r_err_cnt  <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_capture) r_k <= r_k + c_one;
        if (w_ovf_set) r_overflow <= 1'b1;
        if (r_cap_vld) begin
          if (w_match) r_pass_cnt <= r_pass_cnt + c_one;
          else         r_err_cnt  <= r_err_cnt + c_one;
        end
      end
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  logic                r_fe_vld;
  logic [IDX_W-1:0]    r_fe_idx;
  logic [2*ADDR_W-1:0] r_fe_got;
  logic [2*ADDR_W-1:0] r_fe_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_vld <= 1'b0;
      r_fe_idx <= '0;
      r_fe_got <= '0;
      r_fe_exp <= '0;
    end else if (w_start_run) begin
      r_fe_vld <= 1'b0;
      r_fe_idx <= '0;
      r_fe_got <= '0;
      r_fe_exp <= '0;
    end else if (r_cap_vld && !w_match && !r_fe_vld) begin
      r_fe_vld <= 1'b1;
      r_fe_idx <= r_cap_idx;
      r_fe_got <= w_cap_pair;
      r_fe_exp <= w_gold_rd;
    end
  end

  assign first_err_vld = r_fe_vld;
  assign first_err_idx = r_fe_idx;
  assign first_err_got = r_fe_got;
  assign first_err_exp = r_fe_exp;
`endif

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign pass_cnt = r_pass_cnt;
  assign err_cnt  = r_err_cnt;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_dist_sort_result_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_dist_sort_result_checker
// Brief   : Directed bench with an event-level reference model of the checker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dist_sort_result_checker;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              gold_we;
  logic [IDX_W-1:0]  gold_waddr;
  logic [ADDR_W-1:0] gw1, gw2;
  logic              start;
  logic              busy, done, overflow;
  logic [IDX_W:0]    pass_cnt, err_cnt;
`ifdef FIRST_ERR_CAPTURE_EN
  logic              first_err_vld;
  logic [IDX_W-1:0]  first_err_idx;
  logic [5:0]        first_err_got, first_err_exp;
`endif

  always #5 clk = ~clk;

  dist_sort_result_checker_if #(.ADDR_W(ADDR_W)) res_if ();

  dist_sort_result_checker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gold_we        (gold_we),
    .gold_waddr     (gold_waddr),
    .gold_wdata_1st (gw1),
    .gold_wdata_2nd (gw2),
    .start          (start),
    .res            (res_if),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .err_cnt        (err_cnt),
    .overflow       (overflow)
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    .first_err_vld  (first_err_vld),
    .first_err_idx  (first_err_idx),
    .first_err_got  (first_err_got),
    .first_err_exp  (first_err_exp)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: beats accepted at edge t score at edge t+1; run ends at last accept + 2.
  typedef struct {int due; int idx; logic [5:0] got;} upd_t;
  logic [5:0] gm [DEPTH];
  upd_t       m_q[$];
  upd_t       u;
  int         cyc = 0;
  bit         m_run = 0, m_done = 0, m_ovf = 0, pre_run, pre_done;
  int         m_k = 0, m_pass = 0, m_err = 0, m_last = 0;
  bit         m_fe_vld = 0;
  int         m_fe_idx = 0;
  logic [5:0] m_fe_got = '0, m_fe_exp = '0;

  task automatic m_accept();
    m_q.push_back('{cyc + 1, m_k, {res_if.addr_1st, res_if.addr_2nd}});
    m_k++;
    m_last = cyc;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_ovf = 0; m_k = 0; m_pass = 0; m_err = 0;
      m_q.delete();
      m_fe_vld = 0; m_fe_idx = 0; m_fe_got = '0; m_fe_exp = '0;
    end else begin
      cyc++;
      pre_run  = m_run;
      pre_done = m_done;
      while (m_q.size() > 0 && m_q[0].due == cyc) begin
        u = m_q.pop_front();
        if (u.got == gm[u.idx]) m_pass++;
        else begin
          m_err++;
          if (!m_fe_vld) begin
            m_fe_vld = 1; m_fe_idx = u.idx; m_fe_got = u.got; m_fe_exp = gm[u.idx];
          end
        end
      end
      if (pre_run) begin
        if (m_k == DEPTH && cyc >= m_last + 2) begin m_run = 0; m_done = 1; end
        if (res_if.out_valid) begin
          if (m_k < DEPTH) m_accept();
          else             m_ovf = 1;
        end
      end else begin
        if (gold_we && int'(gold_waddr) < DEPTH) gm[gold_waddr] = {gw1, gw2};
        if (start) begin
          m_run = 1; m_done = 0; m_k = 0; m_pass = 0; m_err = 0; m_ovf = 0;
          m_fe_vld = 0; m_fe_idx = 0; m_fe_got = '0; m_fe_exp = '0;
          m_q.delete();
          if (res_if.out_valid) m_accept();
        end else if (pre_done && res_if.out_valid) m_ovf = 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass_cnt", pass_cnt, m_pass);
      chk("err_cnt", err_cnt, m_err);
      chk("overflow", overflow, m_ovf);
`ifdef FIRST_ERR_CAPTURE_EN
      chk("fe_vld", first_err_vld, m_fe_vld);
      chk("fe_idx", first_err_idx, m_fe_idx);
      chk("fe_got", first_err_got, m_fe_got);
      chk("fe_exp", first_err_exp, m_fe_exp);
`endif
    end
  end

  logic [2:0] t1 [4] = '{3'd1, 3'd3, 3'd7, 3'd5};
  logic [2:0] t2 [4] = '{3'd2, 3'd0, 3'd6, 3'd4};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic [2:0] a, input logic [2:0] b);
    res_if.out_valid = 1'b1; res_if.addr_1st = a; res_if.addr_2nd = b;
    @(negedge clk);
    res_if.out_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int idx, input logic [2:0] a, input logic [2:0] b);
    gold_we = 1'b1; gold_waddr = idx[IDX_W-1:0]; gw1 = a; gw2 = b;
    @(negedge clk);
    gold_we = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(nm, done, 1);
  endtask

  task automatic run_table();
    for (int i = 0; i < 4; i++) beat(t1[i], t2[i]);
  endtask

  initial begin
    rst_n = 1'b0; gold_we = 1'b0; gold_waddr = '0; gw1 = '0; gw2 = '0; start = 1'b0;
    res_if.out_valid = 1'b0; res_if.addr_1st = '0; res_if.addr_2nd = '0;
    #1 cmp_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ovf", overflow, 0);

    // Beats before start are pipeline fill
    beat(3'd1, 3'd2); beat(3'd4, 3'd4); beat(3'd7, 3'd0);
    step(2);
    chk("idle_pass", pass_cnt, 0);
    chk("idle_ovf", overflow, 0);

    for (int i = 0; i < 4; i++) load(i, t1[i], t2[i]);

    // All-match run, done two edges after the last beat
    pulse_start();
    chk("t1_busy", busy, 1);
    run_table();
    chk("t1_done_n", done, 0);
    step(1);
    chk("t1_done_n1", done, 0);
    chk("t1_pass_n1", pass_cnt, 4);
    step(1);
    chk("t1_done_n2", done, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_ovf", overflow, 0);

    // Extra beat in DONE, then restart
    beat(3'd0, 3'd0);
    chk("t3_ovf", overflow, 1);
    chk("t3_pass", pass_cnt, 4);
    step(2);
    chk("t3_ovf_sticky", overflow, 1);
    pulse_start();
    chk("t3_ovf_clr", overflow, 0);
    chk("t3_pass_clr", pass_cnt, 0);
    chk("t3_busy", busy, 1);

    // Mismatch at index 2
    beat(3'd1, 3'd2); beat(3'd3, 3'd0); beat(3'd6, 3'd7); beat(3'd5, 3'd4);
    wait_done("t2_done");
    chk("t2_pass", pass_cnt, 3);
    chk("t2_err", err_cnt, 1);
`ifdef FIRST_ERR_CAPTURE_EN
    chk("t2_fe_idx", first_err_idx, 2);
    chk("t2_fe_got", first_err_got, 6'b110_111);
    chk("t2_fe_exp", first_err_exp, 6'b111_110);
`endif

    // Gapped beats; golden writes and a stray start during RUN are ignored
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      int gap;
      beat(t1[i], t2[i]);
      gap = $urandom_range(1, 5);
      if (i == 1) start = 1'b1;
      load((i + 1) % 4, 3'd0, 3'd0);
      start = 1'b0;
      step(gap - 1);
    end
    wait_done("t4_done");
    chk("t4_pass", pass_cnt, 4);
    chk("t4_err", err_cnt, 0);

    // Asynchronous reset mid-run, golden survives
    pulse_start();
    beat(t1[0], t2[0]); beat(t1[1], t2[1]);
    step(1);
    chk("t5_pass_pre", pass_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_pass_rst", pass_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    pulse_start();
    run_table();
    wait_done("t5_done");
    chk("t5_pass", pass_cnt, 4);

    // Start and a beat on the same DONE cycle: beat is index 0
    start = 1'b1;
    beat(t1[0], t2[0]);
    start = 1'b0;
    for (int i = 1; i < 4; i++) beat(t1[i], t2[i]);
    wait_done("t7_done");
    chk("t7_pass", pass_cnt, 4);
    chk("t7_ovf", overflow, 0);

    step(2);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
